riscv_core_mem_arbiter: RTL and testbench

- Shares the core's single AXI memory master between three requesters: I-cache refill, D-cache refill, and the D-cache write-through FIFO drain.
- Sits between both cache controllers, the write-buffer FIFO and the AXI master adapter.
- Grants one transaction at a time and holds the address and data stable until the adapter signals done.
- Returns a one-cycle done pulse to the owner.
- Enforces write-before-read ordering: D-cache refills never overtake buffered stores.

---
 rtl/riscv_core_mem_arbiter.sv | 111 +++++++++++
 tb/tb_riscv_core_mem_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_mem_arbiter.sv
// riscv_core_mem_arbiter: shares one AXI master between I-cache refill, D-cache refill and write-buffer drain.
// Define MEM_ARB_TIMEOUT_EN to enable the transaction watchdog and sticky o_timeout_err.
module riscv_core_mem_arbiter #(
    parameter int ADDR_WIDTH       = 64,
    parameter int DATA_WIDTH       = 64,
    parameter int FIFO_ENTRY_WIDTH = 128,
    parameter int LINE_OFFSET      = 5,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_ic_req,
    input  logic [ADDR_WIDTH-1:0]       i_ic_addr,
    output logic                        o_ic_done,
    input  logic                        i_dc_req,
    input  logic [ADDR_WIDTH-1:0]       i_dc_addr,
    output logic                        o_dc_done,
    input  logic                        i_wb_valid,
    input  logic                        i_wb_full,
    input  logic [FIFO_ENTRY_WIDTH-1:0] i_wb_entry,
    output logic                        o_wb_pop,
    output logic                        o_axi_req,
    output logic                        o_axi_write,
    output logic [ADDR_WIDTH-1:0]       o_axi_addr,
    output logic [DATA_WIDTH-1:0]       o_axi_wdata,
    input  logic                        i_axi_done,
    output logic [1:0]                  o_grant,
    output logic                        o_timeout_err
);
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT_IC = 2'd1, GRANT_DC = 2'd2, GRANT_WB = 2'd3} state_t;

    state_t                  state_q, state_d;
    logic                    rr_q, req_q, write_q, fin, to_hit, unused;
    logic [1:0]              grant_q;
    logic [ADDR_WIDTH-1:0]   addr_q, ic_line, dc_line, wb_addr;
    logic [DATA_WIDTH-1:0]   wdata_q;

    assign ic_line = {i_ic_addr[ADDR_WIDTH-1:LINE_OFFSET], {LINE_OFFSET{1'b0}}};
    assign dc_line = {i_dc_addr[ADDR_WIDTH-1:LINE_OFFSET], {LINE_OFFSET{1'b0}}};
    assign wb_addr = i_wb_entry[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    assign unused  = ^{i_ic_addr[LINE_OFFSET-1:0], i_dc_addr[LINE_OFFSET-1:0], TIMEOUT_CYCLES != 0};

    // Any buffered store blocks a D-cache refill so reads never pass older writes.
    assign state_d = (i_wb_full & i_wb_valid)  ? GRANT_WB :
                     (i_dc_req & i_wb_valid)   ? GRANT_WB :
                     (i_ic_req & i_dc_req)     ? (rr_q ? GRANT_DC : GRANT_IC) :
                     i_ic_req                  ? GRANT_IC :
                     i_dc_req                  ? GRANT_DC :
                     i_wb_valid                ? GRANT_WB : IDLE;

    assign fin         = (state_q != IDLE) & (i_axi_done | to_hit);
    assign o_ic_done   = fin & (state_q == GRANT_IC);
    assign o_dc_done   = fin & (state_q == GRANT_DC);
    assign o_wb_pop    = fin & (state_q == GRANT_WB) & i_wb_valid;
    assign o_axi_req   = req_q;
    assign o_axi_write = write_q;
    assign o_axi_addr  = addr_q;
    assign o_axi_wdata = wdata_q;
    assign o_grant     = grant_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            req_q   <= 1'b0;
            write_q <= 1'b0;
            grant_q <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state_q == IDLE) begin
            state_q <= state_d;
            if (state_d != IDLE) begin
                req_q   <= 1'b1;
                grant_q <= state_d;
                write_q <= state_d == GRANT_WB;
                addr_q  <= state_d == GRANT_WB ? wb_addr : state_d == GRANT_DC ? dc_line : ic_line;
            end
            if (state_d == GRANT_WB) wdata_q <= i_wb_entry[DATA_WIDTH-1:0];
            if (state_d == GRANT_IC) rr_q <= 1'b1;
            if (state_d == GRANT_DC) rr_q <= 1'b0;
        end else if (fin) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            write_q <= 1'b0;
            grant_q <= 2'd0;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;
    logic          err_q;

    assign to_hit        = (state_q != IDLE) & (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign o_timeout_err = err_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == IDLE || fin) ? '0 : cnt_q + CW'(1);
            if (to_hit) err_q <= 1'b1;
        end
    end
`else
    assign to_hit        = 1'b0;
    assign o_timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_riscv_core_mem_arbiter.sv
// tb_riscv_core_mem_arbiter: directed checks of grant order, ordering, round-robin, reset and watchdog.
module tb_riscv_core_mem_arbiter;
    logic         clk = 1'b0, rst_n = 1'b0;
    logic         ic_req = 0, dc_req = 0, wb_valid = 0, wb_full = 0, axi_done = 0;
    logic [63:0]  ic_addr = '0, dc_addr = '0;
    logic [127:0] wb_entry = '0;
    logic         ic_done, dc_done, wb_pop, axi_req, axi_write, timeout_err;
    logic [63:0]  axi_addr, axi_wdata;
    logic [1:0]   grant;
    int           n_chk = 0, n_fail = 0;

    riscv_core_mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ic_req(ic_req), .i_ic_addr(ic_addr), .o_ic_done(ic_done),
        .i_dc_req(dc_req), .i_dc_addr(dc_addr), .o_dc_done(dc_done),
        .i_wb_valid(wb_valid), .i_wb_full(wb_full), .i_wb_entry(wb_entry), .o_wb_pop(wb_pop),
        .o_axi_req(axi_req), .o_axi_write(axi_write), .o_axi_addr(axi_addr), .o_axi_wdata(axi_wdata),
        .i_axi_done(axi_done), .o_grant(grant), .o_timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_txn(input string tag, input int owner);
        axi_done = 1;
        #1;
        check({tag, "_ic_done"}, 64'(ic_done), 64'(owner == 1));
        check({tag, "_dc_done"}, 64'(dc_done), 64'(owner == 2));
        check({tag, "_wb_pop"}, 64'(wb_pop), 64'(owner == 3));
        tick();
        axi_done = 0;
        #1;
        check({tag, "_req_low"}, 64'(axi_req), 64'd0);
        check({tag, "_grant_clr"}, 64'(grant), 64'd0);
        check({tag, "_done_low"}, 64'({ic_done, dc_done, wb_pop}), 64'd0);
    endtask

    initial begin
        #2;
        check("rst_req", 64'(axi_req), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_addr", axi_addr, 64'd0);
        check("rst_wdata", axi_wdata, 64'd0);
        check("rst_write", 64'(axi_write), 64'd0);
        check("rst_err", 64'(timeout_err), 64'd0);
        tick();
        rst_n = 1;
        tick();

        // Stray done in IDLE is ignored
        axi_done = 1;
        #1;
        check("idle_done", 64'({ic_done, dc_done, wb_pop}), 64'd0);
        tick();
        axi_done = 0;
        check("idle_req", 64'(axi_req), 64'd0);

        // IC read only
        ic_req = 1;
        ic_addr = 64'h1234_5678;
        tick();
        check("ic_req", 64'(axi_req), 64'd1);
        check("ic_grant", 64'(grant), 64'd1);
        check("ic_addr", axi_addr, 64'h1234_5660);
        check("ic_write", 64'(axi_write), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ic_wait_done", 64'(ic_done), 64'd0);
        end
        tick();
        check("ic_addr_stable", axi_addr, 64'h1234_5660);
        ic_req = 0;
        finish_txn("ic", 1);

        // Store before D-cache refill
        wb_valid = 1;
        wb_entry = {64'h8000_0010, 64'hDEAD_BEEF};
        dc_req = 1;
        dc_addr = 64'h0000_0000_4000_007F;
        tick();
        check("ord_grant", 64'(grant), 64'd3);
        check("ord_write", 64'(axi_write), 64'd1);
        check("ord_addr", axi_addr, 64'h8000_0010);
        check("ord_wdata", axi_wdata, 64'hDEAD_BEEF);
        axi_done = 1;
        #1;
        check("ord_pop", 64'(wb_pop), 64'd1);
        check("ord_dc_done", 64'(dc_done), 64'd0);
        tick();
        axi_done = 0;
        wb_valid = 0;
        check("ord_req_low", 64'(axi_req), 64'd0);
        tick();
        check("ord_dc_grant", 64'(grant), 64'd2);
        check("ord_dc_addr", axi_addr, 64'h4000_0060);
        check("ord_dc_write", 64'(axi_write), 64'd0);
        dc_req = 0;
        finish_txn("ord_dc", 2);

        // Round-robin from a fresh reset
        rst_n = 0;
        #1;
        rst_n = 1;
        ic_req = 1;
        dc_req = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_grant", 64'(grant), (i % 2) ? 64'd2 : 64'd1);
            finish_txn("rr", (i % 2) ? 2 : 1);
        end
        ic_req = 0;
        dc_req = 0;
        tick();

        // Full write buffer wins over IC, IC follows at D+2
        wb_full = 1;
        wb_valid = 1;
        wb_entry = {64'h0000_0000_9000_0008, 64'h0123_4567_89AB_CDEF};
        ic_req = 1;
        ic_addr = 64'h0000_0000_0000_1FFF;
        tick();
        check("full_grant", 64'(grant), 64'd3);
        check("full_wdata", axi_wdata, 64'h0123_4567_89AB_CDEF);
        axi_done = 1;
        #1;
        check("full_pop", 64'(wb_pop), 64'd1);
        tick();
        axi_done = 0;
        wb_full = 0;
        wb_valid = 0;
        check("full_d1_req", 64'(axi_req), 64'd0);
        tick();
        check("full_d2_grant", 64'(grant), 64'd1);
        check("full_d2_addr", axi_addr, 64'h0000_0000_0000_1FE0);
        ic_req = 0;
        finish_txn("full_ic", 1);

        // Reset during GRANT_DC
        dc_req = 1;
        dc_addr = 64'h0000_0000_0000_0040;
        tick();
        check("rst_dc_grant", 64'(grant), 64'd2);
        axi_done = 1;
        #1;
        check("rst_dc_done_pre", 64'(dc_done), 64'd1);
        rst_n = 0;
        #1;
        check("rst_dc_done", 64'(dc_done), 64'd0);
        check("rst_dc_req", 64'(axi_req), 64'd0);
        check("rst_dc_grant0", 64'(grant), 64'd0);
        axi_done = 0;
        dc_req = 0;
        tick();
        rst_n = 1;
        tick();
        check("rst_dc_idle", 64'(axi_req), 64'd0);
        // Leave rr favouring DC, then reset in IDLE: IC must win afterwards
        ic_req = 1;
        tick();
        ic_req = 0;
        finish_txn("rr_pre", 1);
        rst_n = 0;
        #1;
        rst_n = 1;
        ic_req = 1;
        dc_req = 1;
        tick();
        check("rst_rr_ic", 64'(grant), 64'd1);
        ic_req = 0;
        dc_req = 0;
        finish_txn("rst_rr", 1);

`ifdef MEM_ARB_TIMEOUT_EN
        ic_req = 1;
        ic_addr = 64'h0000_0000_0000_2000;
        tick();
        check("to_grant", 64'(grant), 64'd1);
        for (int i = 1; i < 15; i++) begin
            tick();
            check("to_early", 64'(ic_done), 64'd0);
        end
        tick();
        check("to_done", 64'(ic_done), 64'd1);
        check("to_err_pre", 64'(timeout_err), 64'd0);
        ic_req = 0;
        tick();
        check("to_err", 64'(timeout_err), 64'd1);
        check("to_req_low", 64'(axi_req), 64'd0);
        tick();
        tick();
        check("to_err_sticky", 64'(timeout_err), 64'd1);
`else
        check("no_to_err", 64'(timeout_err), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
